// File: rtl/llnn_axi_master.sv
// AXI4-Lite master that streams a network input vector out as 32-bit words,
// then reads back the network output register. Each write completes its B
// handshake before the next word is issued. A slave error aborts the transaction.
module llnn_axi_master #(
   parameter int unsigned NET_INPUTS  = 400,
   parameter int unsigned NET_OUTPUTS = 4,
   parameter logic [13:0] IN_BASE     = 14'h0000,
   parameter logic [13:0] OUT_ADDR    = 14'h0040
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NET_INPUTS-1:0]  vec_i,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [NET_OUTPUTS-1:0] result_o,
   output logic [13:0]            M_AXI_AWADDR,
   output logic                   M_AXI_AWVALID,
   input  logic                   M_AXI_AWREADY,
   output logic [31:0]            M_AXI_WDATA,
   output logic [3:0]             M_AXI_WSTRB,
   output logic                   M_AXI_WVALID,
   input  logic                   M_AXI_WREADY,
   input  logic [1:0]             M_AXI_BRESP,
   input  logic                   M_AXI_BVALID,
   output logic                   M_AXI_BREADY,
   output logic [13:0]            M_AXI_ARADDR,
   output logic                   M_AXI_ARVALID,
   input  logic                   M_AXI_ARREADY,
   input  logic [31:0]            M_AXI_RDATA,
   input  logic [1:0]             M_AXI_RRESP,
   input  logic                   M_AXI_RVALID,
   output logic                   M_AXI_RREADY
);

   localparam int unsigned NW = (NET_INPUTS + 31) / 32;
   localparam int unsigned VW = NW * 32;
   localparam int unsigned KW = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [KW-1:0] KLast = KW'(NW - 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StWrite = 3'd1;
   localparam logic [2:0] StWresp = 3'd2;
   localparam logic [2:0] StRaddr = 3'd3;
   localparam logic [2:0] StRdata = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;

   logic [2:0]             state_q, state_d;
   logic [KW-1:0]          k_q, k_d;
   // Captured vector, zero-padded to whole words; shifted right one word per write
   logic [VW-1:0]          vec_q, vec_d;
   logic [13:0]            awaddr_q, awaddr_d;
   logic [13:0]            araddr_q, araddr_d;
   logic [3:0]             wstrb_q, wstrb_d;
   logic                   aw_valid_q, aw_valid_d;
   logic                   w_valid_q, w_valid_d;
   logic                   aw_done_q, aw_done_d;
   logic                   w_done_q, w_done_d;
   logic                   err_q, err_d;
   logic [NET_OUTPUTS-1:0] result_q, result_d;
   logic                   aw_fire, w_fire;
   logic                   unused_rdata;

   assign aw_fire = aw_valid_q & M_AXI_AWREADY;
   assign w_fire  = w_valid_q & M_AXI_WREADY;

   // Only the low NET_OUTPUTS bits of the read data carry the result
   assign unused_rdata = ^M_AXI_RDATA;

   // Next-state logic for the transaction FSM and its datapath registers
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      vec_d      = vec_q;
      awaddr_d   = awaddr_q;
      araddr_d   = araddr_q;
      wstrb_d    = wstrb_q;
      aw_valid_d = aw_valid_q;
      w_valid_d  = w_valid_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      err_d      = err_q;
      result_d   = result_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StWrite;
               vec_d      = VW'(vec_i);
               k_d        = '0;
               err_d      = 1'b0;
               awaddr_d   = IN_BASE;
               wstrb_d    = 4'hF;
               aw_valid_d = 1'b1;
               w_valid_d  = 1'b1;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
            end
         end
         StWrite: begin
            // AW and W complete independently; leave once both have handshaken
            if (aw_fire) begin
               aw_valid_d = 1'b0;
               aw_done_d  = 1'b1;
            end
            if (w_fire) begin
               w_valid_d = 1'b0;
               w_done_d  = 1'b1;
            end
            if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
               state_d = StWresp;
            end
         end
         StWresp: begin
            if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else if (k_q == KLast) begin
                  araddr_d = OUT_ADDR;
                  state_d  = StRaddr;
               end else begin
                  k_d        = k_q + KW'(1);
                  vec_d      = vec_q >> 32;
                  awaddr_d   = awaddr_q + 14'd4;
                  aw_valid_d = 1'b1;
                  w_valid_d  = 1'b1;
                  aw_done_d  = 1'b0;
                  w_done_d   = 1'b0;
                  state_d    = StWrite;
               end
            end
         end
         StRaddr: begin
            if (M_AXI_ARREADY) begin
               state_d = StRdata;
            end
         end
         StRdata: begin
            if (M_AXI_RVALID) begin
               result_d = M_AXI_RDATA[NET_OUTPUTS-1:0];
               if (M_AXI_RRESP != 2'b00) begin
                  err_d = 1'b1;
               end
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         k_q        <= '0;
         vec_q      <= '0;
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wstrb_q    <= '0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         err_q      <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         vec_q      <= vec_d;
         awaddr_q   <= awaddr_d;
         araddr_q   <= araddr_d;
         wstrb_q    <= wstrb_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         err_q      <= err_d;
         result_q   <= result_d;
      end
   end

   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWVALID = aw_valid_q;
   assign M_AXI_WDATA   = vec_q[31:0];
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = w_valid_q;
   assign M_AXI_BREADY  = (state_q == StWresp);
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARVALID = (state_q == StRaddr);
   assign M_AXI_RREADY  = (state_q == StRdata);
   assign busy          = (state_q != StIdle) && (state_q != StDone);
   assign done          = (state_q == StDone);
   assign err           = err_q;
   assign result_o      = result_q;

endmodule

// File: tb/tb_llnn_axi_master.sv
// Directed bench for llnn_axi_master with a behavioural AXI4-Lite slave.
module tb_llnn_axi_master;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [399:0] vec = '0;
   logic         busy, done, err;
   logic [3:0]   result_o;
   logic [13:0]  awaddr, araddr;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;

   // Slave-driven signals, updated on the falling edge
   logic         awready = 1'b1, wready = 1'b1, bvalid = 1'b0, arready = 1'b1, rvalid = 1'b0;
   logic [1:0]   bresp = 2'b00, rresp = 2'b00;
   logic [31:0]  rdata = '0;

   // Slave configuration, written only by the stimulus process
   int           stall_word = -1;
   int           stall_cycles = 0;
   int           bresp_err_word = -1;
   logic [31:0]  rdata_val = '0;
   bit           clr_req = 1'b0;

   // Monitor state, written only by the monitor process
   int           aw_hs, w_hs, b_hs, ar_hs, r_hs, done_cnt;
   bit           wstrb_bad;
   logic [13:0]  aw_addr_log[$];
   logic [13:0]  ar_addr_log[$];
   logic [31:0]  w_data_log[$];

   int           stall_cnt = 0;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   llnn_axi_master dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .vec_i        (vec),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .result_o     (result_o),
      .M_AXI_AWADDR (awaddr),
      .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(awready),
      .M_AXI_WDATA  (wdata),
      .M_AXI_WSTRB  (wstrb),
      .M_AXI_WVALID (wvalid),
      .M_AXI_WREADY (wready),
      .M_AXI_BRESP  (bresp),
      .M_AXI_BVALID (bvalid),
      .M_AXI_BREADY (bready),
      .M_AXI_ARADDR (araddr),
      .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(arready),
      .M_AXI_RDATA  (rdata),
      .M_AXI_RRESP  (rresp),
      .M_AXI_RVALID (rvalid),
      .M_AXI_RREADY (rready)
   );

   // Slave: zero-wait by default, optional AWREADY stall on one word, optional BRESP error
   always @(negedge clk) begin
      if (awvalid && aw_hs == stall_word && stall_cnt < stall_cycles) begin
         awready = 1'b0;
         stall_cnt++;
      end else begin
         awready = 1'b1;
         if (!awvalid) stall_cnt = 0;
      end
      wready  = 1'b1;
      bvalid  = (aw_hs > b_hs) && (w_hs > b_hs);
      bresp   = (b_hs == bresp_err_word) ? 2'b10 : 2'b00;
      arready = 1'b1;
      rvalid  = (ar_hs > r_hs);
      rdata   = rdata_val;
      rresp   = 2'b00;
   end

   // Monitor: counts handshakes and done pulses, logs addresses and data
   always @(posedge clk) begin
      if (rst || clr_req) begin
         aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; done_cnt = 0;
         wstrb_bad = 1'b0;
         aw_addr_log.delete();
         ar_addr_log.delete();
         w_data_log.delete();
      end else begin
         if (awvalid && awready) begin aw_addr_log.push_back(awaddr); aw_hs++; end
         if (wvalid && wready) begin
            w_data_log.push_back(wdata);
            w_hs++;
            if (wstrb !== 4'hF) wstrb_bad = 1'b1;
         end
         if (bvalid && bready) b_hs++;
         if (arvalid && arready) begin ar_addr_log.push_back(araddr); ar_hs++; end
         if (rvalid && rready) r_hs++;
         if (done) done_cnt++;
      end
   end

   function automatic logic [31:0] pat_word(input int i);
      logic [31:0] w;
      w = 32'h1111_1111 * 32'(i + 1);
      if (i == 12) w = w & 32'h0000_FFFF;
      return w;
   endfunction

   task automatic clear_counts();
      @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
   endtask

   // Wait (bounded) for done, counting cycles from the start cycle
   task automatic wait_done(input int n0, input bit hold, output int n);
      n = n0;
      while (done !== 1'b1 && n < n0 + 400) begin
         @(negedge clk);
         n++;
         if (!hold) start = 1'b0;
      end
      start = 1'b0;
      if (done !== 1'b1) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_handshake: got %b required 00000",
                  {awvalid, wvalid, bready, arvalid, rready});
      end
      checks++;
      if ({busy, done, err} !== 3'b0) begin
         errors++; $display("FAIL reset_status: got %b required 000", {busy, done, err});
      end
      checks++;
      if (result_o !== 4'h0) begin
         errors++; $display("FAIL reset_result: got %h required 0", result_o);
      end
      checks++;
      if ({awaddr, wdata, araddr, wstrb} !== 64'h0) begin
         errors++;
         $display("FAIL reset_regs: got aw=%h wd=%h ar=%h st=%h required all 0",
                  awaddr, wdata, araddr, wstrb);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int n;
      logic [31:0] exp_w;
      vec = (400'h1 << 399) | 400'h1;
      rdata_val = 32'h0000_000A;
      clear_counts();
      start = 1'b1;
      wait_done(0, 1'b0, n);
      checks++;
      if (n != 29) begin errors++; $display("FAIL basic_latency: got %0d required 29", n); end
      checks++;
      if ({busy, err} !== 2'b00) begin
         errors++; $display("FAIL basic_done_status: got busy,err=%b required 00", {busy, err});
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b required 0", done); end
      checks++;
      if (result_o !== 4'hA) begin errors++; $display("FAIL basic_result: got %h required a", result_o); end
      checks++;
      if (aw_hs != 13 || w_hs != 13 || b_hs != 13 || ar_hs != 1) begin
         errors++;
         $display("FAIL basic_counts: got aw=%0d w=%0d b=%0d ar=%0d required 13 13 13 1",
                  aw_hs, w_hs, b_hs, ar_hs);
      end
      for (int i = 0; i < aw_addr_log.size(); i++) begin
         checks++;
         if (aw_addr_log[i] !== 14'(4 * i)) begin
            errors++; $display("FAIL basic_awaddr[%0d]: got %h required %h", i, aw_addr_log[i], 4 * i);
         end
      end
      for (int i = 0; i < w_data_log.size(); i++) begin
         exp_w = (i == 0) ? 32'h0000_0001 : (i == 12) ? 32'h0000_8000 : 32'h0;
         checks++;
         if (w_data_log[i] !== exp_w) begin
            errors++; $display("FAIL basic_wdata[%0d]: got %h required %h", i, w_data_log[i], exp_w);
         end
      end
      checks++;
      if (ar_addr_log.size() != 1 || ar_addr_log[0] !== 14'h0040) begin
         errors++; $display("FAIL basic_araddr: got %0d reads required one read of 0040",
                            ar_addr_log.size());
      end
      checks++;
      if (wstrb_bad) begin errors++; $display("FAIL basic_wstrb: got non-F strobe required f"); end
   endtask

   task automatic test_w_before_aw();
      int n;
      logic [415:0] tmp;
      logic [13:0] a;
      logic [31:0] d;
      for (int i = 0; i < 13; i++) tmp[32*i +: 32] = 32'h1111_1111 * 32'(i + 1);
      vec = tmp[399:0];
      stall_word = 5;
      stall_cycles = 3;
      rdata_val = 32'h0000_0006;
      clear_counts();
      start = 1'b1;
      n = 0;
      while (!(aw_hs == 5 && awvalid === 1'b1) && n < 200) begin
         @(negedge clk);
         n++;
         start = 1'b0;
      end
      checks++;
      if ({awvalid, wvalid} !== 2'b11) begin
         errors++; $display("FAIL stall_first_cycle: got aw,w valid=%b required 11", {awvalid, wvalid});
      end
      a = awaddr;
      d = wdata;
      checks++;
      if (a !== 14'h0014 || d !== 32'h6666_6666) begin
         errors++; $display("FAIL stall_word5: got addr=%h data=%h required 0014 66666666", a, d);
      end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         n++;
         checks++;
         if ({awvalid, wvalid} !== 2'b10 || awaddr !== a || wdata !== d) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got aw,w=%b addr=%h data=%h required 10 %h %h",
                     j, {awvalid, wvalid}, awaddr, wdata, a, d);
         end
      end
      @(negedge clk);
      n++;
      checks++;
      if ({awvalid, bready} !== 2'b01) begin
         errors++; $display("FAIL stall_to_wresp: got awvalid,bready=%b required 01", {awvalid, bready});
      end
      wait_done(n, 1'b0, n);
      checks++;
      if (n != 32) begin errors++; $display("FAIL stall_latency: got %0d required 32", n); end
      checks++;
      if (aw_hs != 13 || w_hs != 13 || b_hs != 13) begin
         errors++; $display("FAIL stall_counts: got aw=%0d w=%0d b=%0d required 13 13 13",
                            aw_hs, w_hs, b_hs);
      end
      for (int i = 0; i < w_data_log.size(); i++) begin
         checks++;
         if (w_data_log[i] !== pat_word(i)) begin
            errors++;
            $display("FAIL stall_wdata[%0d]: got %h required %h", i, w_data_log[i], pat_word(i));
         end
      end
      @(negedge clk);
      checks++;
      if (result_o !== 4'h6 || err !== 1'b0) begin
         errors++; $display("FAIL stall_result: got %h err=%b required 6 err=0", result_o, err);
      end
      stall_word = -1;
   endtask

   task automatic test_bresp_err();
      int n;
      bresp_err_word = 2;
      rdata_val = 32'h0000_0003;
      clear_counts();
      start = 1'b1;
      wait_done(0, 1'b0, n);
      checks++;
      if (n != 7) begin errors++; $display("FAIL abort_latency: got %0d required 7", n); end
      checks++;
      if ({err, busy} !== 2'b10) begin
         errors++; $display("FAIL abort_err: got err,busy=%b required 10", {err, busy});
      end
      repeat (4) @(negedge clk);
      checks++;
      if (aw_hs != 3 || b_hs != 3 || ar_hs != 0) begin
         errors++; $display("FAIL abort_counts: got aw=%0d b=%0d ar=%0d required 3 3 0",
                            aw_hs, b_hs, ar_hs);
      end
      checks++;
      if (result_o !== 4'h6) begin
         errors++; $display("FAIL abort_result_kept: got %h required 6", result_o);
      end
      bresp_err_word = -1;
   endtask

   task automatic test_rdata_hold();
      int n;
      rdata_val = 32'hFFFF_FFF5;
      clear_counts();
      start = 1'b1;
      wait_done(0, 1'b1, n);
      checks++;
      if (n != 29 || err !== 1'b0) begin
         errors++; $display("FAIL hold_done: got cycles=%0d err=%b required 29 err=0", n, err);
      end
      @(negedge clk);
      checks++;
      if (result_o !== 4'h5) begin errors++; $display("FAIL hold_result: got %h required 5", result_o); end
      repeat (3) @(negedge clk);
      checks++;
      if (aw_hs != 13 || ar_hs != 1 || done_cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_single_txn: got aw=%0d ar=%0d dones=%0d busy=%b required 13 1 1 0",
                  aw_hs, ar_hs, done_cnt, busy);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      rdata_val = 32'h0000_0009;
      clear_counts();
      start = 1'b1;
      n = 0;
      while (!(bready === 1'b1 && aw_hs == 8) && n < 200) begin
         @(negedge clk);
         n++;
         start = 1'b0;
      end
      checks++;
      if (busy !== 1'b1 || bready !== 1'b1) begin
         errors++; $display("FAIL midrst_wresp7: got busy=%b bready=%b required 1 1", busy, bready);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({awvalid, wvalid, bready, arvalid, rready, busy, done} !== 7'b0) begin
         errors++;
         $display("FAIL midrst_outputs: got %b required 0000000",
                  {awvalid, wvalid, bready, arvalid, rready, busy, done});
      end
      checks++;
      if (result_o !== 4'h0 || awaddr !== 14'h0) begin
         errors++; $display("FAIL midrst_regs: got result=%h awaddr=%h required 0 0", result_o, awaddr);
      end
      rst = 1'b0;
      start = 1'b1;
      wait_done(0, 1'b0, n);
      checks++;
      if (n != 29 || err !== 1'b0) begin
         errors++; $display("FAIL midrst_restart: got cycles=%0d err=%b required 29 err=0", n, err);
      end
      @(negedge clk);
      checks++;
      if (result_o !== 4'h9 || done_cnt != 1 || aw_hs != 13) begin
         errors++;
         $display("FAIL midrst_complete: got result=%h dones=%0d aw=%0d required 9 1 13",
                  result_o, done_cnt, aw_hs);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_w_before_aw();
      test_bresp_err();
      test_rdata_hold();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/llnn_axi_master.md
LLNN_AXI_MASTER -- requirements
Module: llnn_axi_master

Interface
REQ-001 SHALL have parameter NET_INPUTS, default 400, network input vector width.
REQ-002 SHALL have parameter NET_OUTPUTS, default 4, network output width (1..32).
REQ-003 SHALL have parameter IN_BASE, default 14'h0000, byte address of input word 0.
REQ-004 SHALL have parameter OUT_ADDR, default 14'h0040, byte address of output register.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  request one inference transaction; sampled only in IDLE.
REQ-009 vec_i  in  NET_INPUTS  input vector; captured on accepted start.
REQ-010 busy  out  1  high from accepted start until done.
REQ-011 done  out  1  one-cycle pulse when transaction completes or aborts.
REQ-012 err  out  1  valid with done; 1 = a non-OKAY BRESP or RRESP was received.
REQ-013 result_o  out  NET_OUTPUTS  RDATA[NET_OUTPUTS-1:0] of the output read; held until next done.
REQ-014 M_AXI_AWADDR out 14, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1: write address channel.
REQ-015 M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1: write data channel.
REQ-016 M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1: write response channel.
REQ-017 M_AXI_ARADDR out 14, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1: read address channel.
REQ-018 M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1: read data channel.

Function
REQ-019 SHALL implement states IDLE, WRITE, WRESP, RADDR, RDATA, DONE.
REQ-020 IDLE: start=1 -> capture vec_i, word index k=0, err=0, go WRITE; start ignored in all other states.
REQ-021 Word count NW = ceil(NET_INPUTS/32) (13 at default); word k = vec[32k+31:32k], bits beyond NET_INPUTS-1 driven 0.
REQ-022 WRITE: AWADDR = IN_BASE + 4k, WDATA = word k, WSTRB = 4'hF; AWVALID and WVALID asserted together in the first WRITE cycle.
REQ-023 Each of AWVALID/WVALID SHALL drop the cycle after its own handshake (VALID&READY) and SHALL not drop before it; address and data stable while VALID is high.
REQ-024 AW and W handshakes in any order or same cycle; go WRESP once both are done.
REQ-025 WRESP: BREADY=1; on BVALID, BRESP!=2'b00 sets err and goes DONE (abort); else k==NW-1 -> RADDR, else k++ and -> WRITE.
REQ-026 At most one outstanding write; next AWVALID no earlier than the cycle after B handshake.
REQ-027 RADDR: ARADDR = OUT_ADDR, ARVALID=1 until ARREADY, then -> RDATA.
REQ-028 RDATA: RREADY=1; on RVALID latch result_o, set err if RRESP!=2'b00, -> DONE.
REQ-029 DONE: done=1 for exactly one cycle, busy=0 the same cycle, -> IDLE; result_o unchanged on write abort.
REQ-030 Zero-wait-state slave (READY high, response next cycle): one word SHALL take 2 cycles (WRITE, WRESP); full transaction 2*NW+3 cycles from start to done (29 at default).
REQ-031 BREADY/RREADY SHALL be low outside WRESP/RDATA; BVALID/RVALID outside those states ignored.
REQ-032 No timeout; a stalled slave holds the FSM in the current state indefinitely.

Reset
REQ-033 rst=1 SHALL force IDLE, all VALID/READY outputs 0, busy=0, done=0, err=0, result_o=0, k=0, AWADDR/WDATA/ARADDR=0, WSTRB=0.
REQ-034 rst mid-transaction SHALL abandon it next edge with no done pulse; start in the first cycle after rst deassertion SHALL be accepted.

Verification
REQ-035 Zero-wait slave, vec_i=400'h1 <<399 | 1, start -> 13 writes to 0x00..0x30, word0=0x00000001, word12=0x00008000, read 0x40, done at cycle 29.
REQ-036 Slave asserts WREADY 3 cycles before AWREADY on word 5 -> WVALID drops after W handshake, AWVALID held, single B handshake, data unchanged.
REQ-037 BRESP=2'b10 on word 2 -> no further AW/AR, done with err=1, result_o keeps previous value.
REQ-038 RDATA=32'hFFFF_FFF5, RRESP=OKAY -> result_o=4'h5, err=0; start held high through busy -> exactly one transaction.
REQ-039 rst asserted during WRESP of word 7 -> all VALIDs 0 next cycle, no done, new start completes normally.
